int_flag_sequencer: RTL

//  Interrupt entry/exit sequencer for the MCU flag datapath. Synchronises an external

---
 rtl/int_flag_sequencer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/int_flag_sequencer.sv
// Interrupt entry/exit sequencer: synchronises INTR, latches it pending, and
// drives the flag shadow save on entry and the shadow restore on RETIE.
module int_flag_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter bit EDGE_MODE   = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic INTR,
    input  logic INT_SET,
    input  logic INT_CLR,
    input  logic INSTR_BNDRY,
    input  logic RETIE_REQ,
    output logic I_FLAG,
    output logic INT_PEND,
    output logic INT_ACK,
    output logic FLG_SHAD_LD,
    output logic FLG_LD_SEL,
    output logic FLG_RESTORE,
    output logic IN_SERVICE,
    output logic RETIE_ERR
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_ISR   = 2'd2,
        ST_EXIT  = 2'd3
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   s_intr;
    logic                   s_intr_p1;
    logic                   set_evt;
    logic                   set_p2;
    logic                   take_int;
    logic                   take_exit;

    assign s_intr = sync_p0[SYNC_STAGES-1];
    assign set_evt = EDGE_MODE ? (s_intr & ~s_intr_p1) : s_intr;

    // Entry is decided on the boundary cycle itself, so the I_FLAG clear and the
    // pending clear land on the same edge that makes INT_ACK visible.
    assign take_int  = (state == ST_IDLE) & INT_PEND & I_FLAG & INSTR_BNDRY;
    assign take_exit = (state == ST_ISR) & RETIE_REQ;

    // Stage p0: synchroniser chain on the asynchronous request line
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_p0 <= '0;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], INTR};
        end
    end

    // Stage p1/p2: edge register and registered set event
    always_ff @(posedge CLK) begin
        if (RST) begin
            s_intr_p1 <= 1'b0;
            set_p2    <= 1'b0;
        end else begin
            s_intr_p1 <= s_intr;
            set_p2    <= set_evt;
        end
    end

    // Pending latch: a set arriving with the entry clear is kept
    always_ff @(posedge CLK) begin
        if (RST) begin
            INT_PEND <= 1'b0;
        end else begin
            INT_PEND <= set_p2 | (INT_PEND & ~take_int);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            I_FLAG <= 1'b0;
        end else if (take_int) begin
            I_FLAG <= 1'b0;
        end else if (take_exit) begin
            I_FLAG <= 1'b1;
        end else if (INT_CLR) begin
            I_FLAG <= 1'b0;
        end else if (INT_SET) begin
            I_FLAG <= 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (take_int)  state_nxt = ST_ENTRY;
            ST_ENTRY: state_nxt = ST_ISR;
            ST_ISR:   if (take_exit) state_nxt = ST_EXIT;
            ST_EXIT:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they align with the state flops
    always_ff @(posedge CLK) begin
        if (RST) begin
            INT_ACK     <= 1'b0;
            FLG_SHAD_LD <= 1'b0;
            FLG_LD_SEL  <= 1'b0;
            FLG_RESTORE <= 1'b0;
            IN_SERVICE  <= 1'b0;
            RETIE_ERR   <= 1'b0;
        end else begin
            INT_ACK     <= (state_nxt == ST_ENTRY);
            FLG_SHAD_LD <= (state_nxt == ST_ENTRY);
            FLG_LD_SEL  <= (state_nxt == ST_EXIT);
            FLG_RESTORE <= (state_nxt == ST_EXIT);
            IN_SERVICE  <= (state_nxt == ST_ENTRY) | (state_nxt == ST_ISR);
            RETIE_ERR   <= RETIE_REQ & (state != ST_ISR);
        end
    end

endmodule
